// File: rtl/sram_sched_pkg.sv
// sram_sched_pkg
// Shared definitions for the SRAM FIFO command scheduler:
//   state_t            scheduler FSM states
//   GNT_WR / GNT_RD    bit positions of the write / read side in req/gnt vectors
//   RD_TIMEOUT_DEFAULT default read-response timeout in cycles
package sram_sched_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ISSUE = 3'd1,
    WR_WAIT  = 3'd2,
    RD_ISSUE = 3'd3,
    RD_WAIT  = 3'd4
  } state_t;

  localparam int GNT_WR = 0;
  localparam int GNT_RD = 1;

  localparam int RD_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter. A lone requester always wins; on a tie the
// side that was not granted last wins. The "last granted" pointer moves on
// every advance that carries a grant.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   req[1:0]    requests, indexed by GNT_WR / GNT_RD
//   advance     grant is being consumed this cycle; update the pointer
//   gnt[1:0]    one-hot (or zero) grant, combinational from req
module rr_arb2
  import sram_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // 1 = read was granted last, so write wins the next tie.
  logic last_rd_reg;

  always_comb begin
    gnt = 2'b00;
    if (req[GNT_WR] && req[GNT_RD]) begin
      if (last_rd_reg) gnt[GNT_WR] = 1'b1;
      else             gnt[GNT_RD] = 1'b1;
    end else begin
      gnt = req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_rd_reg <= 1'b1;
    end else if (advance && (gnt != 2'b00)) begin
      last_rd_reg <= gnt[GNT_RD];
    end
  end

endmodule

// File: rtl/sram_fifo_sched.sv
// sram_fifo_sched
// Arbitrates a producer (write) and a consumer (read) onto a single SRAM
// FIFO command port, one outstanding command at a time.
// Ports:
//   clk, rst_n              clock / asynchronous active-low reset
//   wr_req, wr_data         producer request (level) and word
//   wr_done, wr_err         one-cycle completion pulse, err = overflow reject
//   rd_req                  consumer request (level)
//   rd_data                 last successfully read word
//   rd_done, rd_err         one-cycle completion pulse, err = empty/timeout
//   f_we, f_re, f_data_in   FIFO command pulses and write word
//   f_data_out, f_data_r_rdy, f_busy, f_overflow, f_empty  FIFO status
module sram_fifo_sched
  import sram_sched_pkg::*;
#(
  parameter int RD_TIMEOUT = RD_TIMEOUT_DEFAULT,
  parameter int DW         = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_req,
  input  logic [DW-1:0] wr_data,
  output logic          wr_done,
  output logic          wr_err,
  input  logic          rd_req,
  output logic [DW-1:0] rd_data,
  output logic          rd_done,
  output logic          rd_err,
  output logic          f_we,
  output logic          f_re,
  output logic [DW-1:0] f_data_in,
  input  logic [DW-1:0] f_data_out,
  input  logic          f_data_r_rdy,
  input  logic          f_busy,
  input  logic          f_overflow,
  input  logic          f_empty
);

  localparam int CW = (RD_TIMEOUT < 1) ? 1 : $clog2(RD_TIMEOUT + 1);
  localparam logic [CW:0] TMO_LIMIT = RD_TIMEOUT[CW:0];

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic [CW:0]     cnt_inc;
  logic            tmo_hit;
  logic            wr_gap_ok;
  logic            arb_go;
  logic [1:0]      arb_req, gnt;
  logic            gnt_wr, gnt_rd;
  logic            wr_done_reg, wr_err_reg, rd_done_reg, rd_err_reg;
  logic [DW-1:0]   f_data_in_reg, rd_data_reg;

  // Requests are only looked at in IDLE while the FIFO is free, so the
  // arbiter pointer only moves on real grants.
  assign arb_go           = (state_reg == IDLE) && !f_busy;
  assign arb_req[GNT_WR]  = arb_go && wr_req;
  assign arb_req[GNT_RD]  = arb_go && rd_req;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .advance (arb_go),
    .gnt     (gnt)
  );

  assign gnt_wr = gnt[GNT_WR];
  assign gnt_rd = gnt[GNT_RD];

  // The counter is cleared in either ISSUE state. In WR_WAIT a nonzero value
  // means at least two cycles have passed since the f_we pulse; in RD_WAIT it
  // is the timeout count. It saturates at RD_TIMEOUT.
  assign cnt_inc   = {1'b0, cnt_reg} + {{CW{1'b0}}, 1'b1};
  assign tmo_hit   = (cnt_inc >= TMO_LIMIT);
  assign wr_gap_ok = (cnt_reg != '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (gnt_wr && !f_overflow)   state_next = WR_ISSUE;
        else if (gnt_rd && !f_empty) state_next = RD_ISSUE;
      end
      WR_ISSUE: state_next = WR_WAIT;
      WR_WAIT:  if (wr_gap_ok && !f_busy) state_next = IDLE;
      RD_ISSUE: state_next = RD_WAIT;
      RD_WAIT:  if (f_data_r_rdy || tmo_hit) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Command outputs
  always_comb begin
    f_we = 1'b0;
    f_re = 1'b0;
    case (state_reg)
      WR_ISSUE: f_we = 1'b1;
      RD_ISSUE: f_re = 1'b1;
      default: ;
    endcase
  end

  // Registered completion pulses, data latches and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_done_reg   <= 1'b0;
      wr_err_reg    <= 1'b0;
      rd_done_reg   <= 1'b0;
      rd_err_reg    <= 1'b0;
      f_data_in_reg <= '0;
      rd_data_reg   <= '0;
      cnt_reg       <= '0;
    end else begin
      wr_done_reg <= 1'b0;
      wr_err_reg  <= 1'b0;
      rd_done_reg <= 1'b0;
      rd_err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (gnt_wr) begin
            if (f_overflow) begin
              wr_done_reg <= 1'b1;
              wr_err_reg  <= 1'b1;
            end else begin
              f_data_in_reg <= wr_data;
            end
          end
          if (gnt_rd && f_empty) begin
            rd_done_reg <= 1'b1;
            rd_err_reg  <= 1'b1;
          end
        end
        WR_ISSUE, RD_ISSUE: cnt_reg <= '0;
        WR_WAIT: begin
          if (wr_gap_ok && !f_busy) wr_done_reg <= 1'b1;
          if (cnt_inc <= TMO_LIMIT) cnt_reg <= cnt_inc[CW-1:0];
        end
        RD_WAIT: begin
          if (f_data_r_rdy) begin
            rd_data_reg <= f_data_out;
            rd_done_reg <= 1'b1;
          end else if (tmo_hit) begin
            rd_done_reg <= 1'b1;
            rd_err_reg  <= 1'b1;
          end
          if (cnt_inc <= TMO_LIMIT) cnt_reg <= cnt_inc[CW-1:0];
        end
        default: ;
      endcase
    end
  end

  assign wr_done   = wr_done_reg;
  assign wr_err    = wr_err_reg;
  assign rd_done   = rd_done_reg;
  assign rd_err    = rd_err_reg;
  assign f_data_in = f_data_in_reg;
  assign rd_data   = rd_data_reg;

endmodule

// File: tb/tb_sram_fifo_sched.sv
// tb_sram_fifo_sched
// Directed and randomized transactions against sram_fifo_sched with a
// transaction-level reference: grant choice, completion latency, error flag,
// command counts and held read data are predicted from the scheduling rules.
module tb_sram_fifo_sched;

  localparam int T  = 4;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          wr_req;
  logic [DW-1:0] wr_data;
  logic          wr_done, wr_err;
  logic          rd_req;
  logic [DW-1:0] rd_data;
  logic          rd_done, rd_err;
  logic          f_we, f_re;
  logic [DW-1:0] f_data_in;
  logic [DW-1:0] f_data_out;
  logic          f_data_r_rdy, f_busy, f_overflow, f_empty;

  sram_fifo_sched #(.RD_TIMEOUT(T), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_req       (wr_req),
    .wr_data      (wr_data),
    .wr_done      (wr_done),
    .wr_err       (wr_err),
    .rd_req       (rd_req),
    .rd_data      (rd_data),
    .rd_done      (rd_done),
    .rd_err       (rd_err),
    .f_we         (f_we),
    .f_re         (f_re),
    .f_data_in    (f_data_in),
    .f_data_out   (f_data_out),
    .f_data_r_rdy (f_data_r_rdy),
    .f_busy       (f_busy),
    .f_overflow   (f_overflow),
    .f_empty      (f_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: which side was granted last, and the word rd_data holds.
  bit          last_rd_m;
  logic [31:0] rd_model;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " ctl"}, {58'd0, f_we, f_re, wr_done, wr_err, rd_done, rd_err}, 64'd0);
    chk({tag, " f_data_in"}, {32'd0, f_data_in}, 64'd0);
    chk({tag, " rd_data"}, {32'd0, rd_data}, 64'd0);
  endtask

  // One request window in IDLE (interval 0), then requests drop. The FIFO
  // model holds f_busy for b cycles after f_we and answers a read d cycles
  // after f_re.
  task automatic run_txn(input string tag, input bit want_wr, input bit want_rd,
                         input bit ovf, input bit emp, input int b, input int d,
                         input logic [31:0] wd, input logic [31:0] rdv);
    bit          g_wr, exp_err;
    int          exp_lat, exp_we, exp_re;
    int          lat, nwe, nre, both, stray, we_at;
    logic [31:0] fdi;
    bit          got_wr, got_rd, got_err;

    g_wr      = want_wr && (!want_rd || last_rd_m);
    last_rd_m = !g_wr;
    exp_we = 0; exp_re = 0; exp_err = 0; exp_lat = 1;
    if (g_wr) begin
      if (ovf) begin
        exp_lat = 1; exp_err = 1;
      end else begin
        exp_lat = (3 + b > 4) ? 3 + b : 4; exp_we = 1;
      end
    end else begin
      if (emp) begin
        exp_lat = 1; exp_err = 1;
      end else begin
        exp_re = 1;
        if (d <= T) begin
          exp_lat = 2 + d; rd_model = rdv;
        end else begin
          exp_lat = T + 2; exp_err = 1;
        end
      end
    end

    wr_req = want_wr; rd_req = want_rd; wr_data = wd;
    f_overflow = ovf; f_empty = emp; f_busy = 1'b0;
    f_data_r_rdy = 1'b0; f_data_out = ~rdv;

    lat = -1; nwe = 0; nre = 0; both = 0; stray = 0; we_at = -1; fdi = '0;
    got_wr = 0; got_rd = 0; got_err = 0;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      tick();
      wr_req = 1'b0; rd_req = 1'b0; wr_data = ~wd;
      f_busy       = (i >= 2) && (i <= 1 + b);
      f_data_r_rdy = (i == 1 + d);
      f_data_out   = f_data_r_rdy ? rdv : ~rdv;
      if (f_we) begin nwe++; if (we_at < 0) we_at = i; fdi = f_data_in; end
      if (f_re) nre++;
      if (f_we && f_re) both++;
      if ((wr_err && !wr_done) || (rd_err && !rd_done)) stray++;
      if (wr_done || rd_done) begin
        lat = i; got_wr = wr_done; got_rd = rd_done;
        got_err = wr_done ? wr_err : rd_err;
      end
    end
    f_busy = 1'b0; f_data_r_rdy = 1'b0;

    $display("txn %s: grant=%s lat=%0d/%0d err=%0b/%0b rd_data=%h",
             tag, g_wr ? "W" : "R", lat, exp_lat, got_err, exp_err, rd_data);
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " done side"}, {62'd0, got_rd, got_wr}, g_wr ? 64'd1 : 64'd2);
    chk({tag, " err"}, {63'd0, got_err}, {63'd0, exp_err});
    chk({tag, " f_we count"}, 64'(nwe), 64'(exp_we));
    chk({tag, " f_re count"}, 64'(nre), 64'(exp_re));
    chk({tag, " we/re overlap"}, 64'(both), 64'd0);
    chk({tag, " err w/o done"}, 64'(stray), 64'd0);
    chk({tag, " rd_data"}, {32'd0, rd_data}, {32'd0, rd_model});
    if (exp_we == 1) begin
      chk({tag, " f_we cycle"}, 64'(we_at), 64'd1);
      chk({tag, " f_data_in"}, {32'd0, fdi}, {32'd0, wd});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          order[$];
    int          first_at, both, hits, dn;
    logic [3:0]  pat;
    bit          kw, kr;

    rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; wr_data = '0;
    f_data_out = '0; f_data_r_rdy = 1'b0; f_busy = 1'b0;
    f_overflow = 1'b0; f_empty = 1'b0;
    last_rd_m = 1'b1; rd_model = '0;

    // Reset state
    tick(); tick();
    check_all_zero("reset");
    rst_n = 1'b1;

    // Tie held high from reset: W,R,W,R
    wr_req = 1'b1; rd_req = 1'b1; f_data_r_rdy = 1'b1; f_data_out = 32'hC0FFEE01;
    first_at = -1; both = 0;
    for (int i = 1; i <= 60 && order.size() < 4; i++) begin
      tick();
      if (f_we && f_re) both++;
      if (f_we) order.push_back(0);
      if (f_re) order.push_back(1);
      if (first_at < 0 && (f_we || f_re)) first_at = i;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    for (int i = 0; i < 10 && !rd_done; i++) tick();
    chk("tie drain rd_done", {63'd0, rd_done}, 64'd1);
    f_data_r_rdy = 1'b0;
    for (int k = 0; k < 4; k++) pat[3-k] = (k < order.size()) ? order[k][0] : 1'bx;
    chk("tie order", {60'd0, pat}, 64'h5);
    chk("tie first grant cycle", 64'(first_at), 64'd1);
    chk("tie overlap", 64'(both), 64'd0);
    last_rd_m = 1'b1; rd_model = 32'hC0FFEE01;
    chk("tie rd_data", {32'd0, rd_data}, {32'd0, rd_model});
    $display("txn tie-held: order=%b", pat);
    tick();

    // Directed transactions
    run_txn("write A5",      1, 0, 0, 0, 0, 1, 32'h0000_00A5, 32'h0);
    run_txn("overflow",      1, 0, 1, 0, 0, 1, 32'h1111_2222, 32'h0);
    run_txn("read d1",       0, 1, 0, 0, 0, 1, 32'h0, 32'h1234_5678);
    run_txn("empty read",    0, 1, 0, 1, 0, 1, 32'h0, 32'hDEAD_0001);
    run_txn("read d4 edge",  0, 1, 0, 0, 0, 4, 32'h0, 32'h0BEE_F004);
    run_txn("read timeout",  0, 1, 0, 0, 0, 9, 32'h0, 32'hBAD0_BAD0);
    run_txn("write busy3",   1, 0, 0, 0, 3, 1, 32'h5A5A_0003, 32'h0);

    // FIFO busy in IDLE: nothing granted
    wr_req = 1'b1; rd_req = 1'b1; f_busy = 1'b1; hits = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (f_we || f_re || wr_done || rd_done) hits++;
    end
    wr_req = 1'b0; rd_req = 1'b0; f_busy = 1'b0;
    chk("busy idle no grant", 64'(hits), 64'd0);
    $display("txn busy-idle: activity=%0d", hits);
    tick();

    // Rejected grant still advances the round-robin pointer
    run_txn("tie ovf",       1, 1, 1, 0, 0, 1, 32'h7777_0001, 32'h0);
    run_txn("tie after rej", 1, 1, 1, 0, 0, 2, 32'h7777_0002, 32'hA1B2_C3D4);

    // Reset during WR_WAIT
    wr_req = 1'b1; wr_data = 32'h0BAD_F00D;
    tick();
    wr_req = 1'b0; f_busy = 1'b1;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid reset");
    f_busy = 1'b0; dn = 0;
    tick(); if (wr_done) dn++;
    tick(); if (wr_done) dn++;
    chk("mid reset no done", 64'(dn), 64'd0);
    rst_n = 1'b1;
    last_rd_m = 1'b1; rd_model = '0;
    run_txn("tie post-reset", 1, 1, 0, 0, 0, 1, 32'hFEED_0040, 32'h0);

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0:       begin kw = 1; kr = 0; end
        1:       begin kw = 0; kr = 1; end
        default: begin kw = 1; kr = 1; end
      endcase
      run_txn($sformatf("rand%0d", n), kw, kr,
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              int'($urandom_range(0, 3)), int'($urandom_range(1, 6)),
              $urandom, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_fifo_sched.md
SRAM_FIFO_SCHED -- requirements
Module: sram_fifo_sched

Interface
REQ-001 SHALL have parameter RD_TIMEOUT, default 255, max cycles to wait for f_data_r_rdy after a read pulse.
REQ-002 SHALL have parameter DW, default 32, data width of both ports.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 wr_req  in  1  producer write request, level.
REQ-006 wr_data  in  DW  producer write word.
REQ-007 wr_done  out  1  one-cycle pulse: write finished or rejected.
REQ-008 wr_err  out  1  valid with wr_done; 1 = rejected, FIFO overflow.
REQ-009 rd_req  in  1  consumer read request, level.
REQ-010 rd_data  out  DW  read word, held until the next successful read.
REQ-011 rd_done  out  1  one-cycle pulse: read finished, rejected or timed out.
REQ-012 rd_err  out  1  valid with rd_done; 1 = FIFO empty or timeout.
REQ-013 f_we, f_re  out  1 each  one-cycle command pulses to the SRAM FIFO.
REQ-014 f_data_in  out  DW  word presented to the FIFO.
REQ-015 f_data_out  in  DW; f_data_r_rdy, f_busy, f_overflow, f_empty  in  1 each  FIFO status.

Function
REQ-016 States SHALL be IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT.
REQ-017 In IDLE with f_busy=1, SHALL stay in IDLE and grant nothing.
REQ-018 In IDLE with f_busy=0:
- only wr_req -> write grant.
- only rd_req -> read grant.
- both -> grant the side not granted last (round-robin).
REQ-019 Write grant with f_overflow=1 SHALL assert wr_done=1, wr_err=1 next cycle, issue no f_we, and stay in IDLE.
REQ-020 Read grant with f_empty=1 SHALL assert rd_done=1, rd_err=1 next cycle, issue no f_re, and stay in IDLE.
REQ-021 Accepted write grant:
- latch wr_data into f_data_in and go to WR_ISSUE.
- WR_ISSUE drives f_we=1 for exactly one cycle, then goes to WR_WAIT.
REQ-022 WR_WAIT SHALL exit to IDLE, with wr_done=1 and wr_err=0, on the first cycle f_busy=0 that is at least 2 cycles after the f_we pulse.
REQ-023 Accepted read grant:
- go to RD_ISSUE.
- RD_ISSUE drives f_re=1 for exactly one cycle, then goes to RD_WAIT and clears the timeout counter.
REQ-024 In RD_WAIT, f_data_r_rdy=1 SHALL capture f_data_out into rd_data and pulse rd_done=1, rd_err=0 in the same cycle, then return to IDLE.
REQ-025 RD_WAIT SHALL count cycles; on reaching RD_TIMEOUT with no f_data_r_rdy, it pulses rd_done=1, rd_err=1, keeps rd_data unchanged, and returns to IDLE.
REQ-026 Timeout counter width SHALL be clog2(RD_TIMEOUT+1) and SHALL saturate, never wrap.
REQ-027 wr_req and rd_req SHALL be sampled only in IDLE; a request still high in the IDLE cycle after its done pulse is a new request.
REQ-028 The round-robin pointer SHALL update on every grant, including rejected ones.
REQ-029 f_we and f_re SHALL never be high in the same cycle; at most one command is outstanding.
REQ-030 wr_err and rd_err SHALL be 0 whenever their done pulse is 0.
REQ-031 Minimum latency SHALL be: grant to f_we 1 cycle; write request to wr_done 4 cycles; read request to rd_done 3 cycles plus FIFO latency.

Reset
REQ-032 rst_n low SHALL immediately force:
- state IDLE.
- f_we=f_re=0, wr_done=rd_done=wr_err=rd_err=0.
- f_data_in=0, rd_data=0, timeout counter=0.
- round-robin pointer = "read last", so write wins the first tie.
REQ-033 Reset mid-operation SHALL abort with no done pulse; the first grant follows the first rising edge after rst_n deasserts.

Structure
REQ-034 State encoding, grant constants (GNT_WR=0, GNT_RD=1) and default RD_TIMEOUT SHALL live in package sram_sched_pkg.
REQ-035 The 2-way round-robin decision SHALL be sub-module rr_arb2 (inputs req[1:0], advance; output gnt[1:0]).

Verification
REQ-036 Write: wr_req=1, wr_data=0x000000A5, FIFO idle -> f_we pulse 1 cycle after grant with f_data_in=0xA5; wr_done=1, wr_err=0.
REQ-037 Tie: wr_req=rd_req=1 held after reset -> grant order W,R,W,R; f_we and f_re never coincide.
REQ-038 Empty read: f_empty=1, rd_req=1 -> rd_done=1, rd_err=1 one cycle later; no f_re.
REQ-039 Timeout: RD_TIMEOUT=4, f_data_r_rdy held 0 -> rd_done=1, rd_err=1 exactly 4 cycles into RD_WAIT; rd_data unchanged.
REQ-040 Reset: rst_n pulsed low during WR_WAIT -> all outputs 0 at once, no wr_done; next tie grants write.
REQ-041 Overflow: f_overflow=1, wr_req=1 -> wr_done=1, wr_err=1; no f_we issued.
